// File: rtl/md_sched_ctrl.sv
// Sequencing controller for the HI/LO multiply/divide unit: decodes E-stage MD
// requests, tracks unit occupancy with a countdown and stalls D-stage MD ops.
module md_sched_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_md,
    input  logic             e_req,
    input  logic             e_kill,
    input  logic [2:0]       e_kind,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic [1:0]       md_we,
    output logic             rd_hi,
    output logic             busy,
    output logic [4:0]       cnt,
    output logic             stall_d,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);

    logic live;
    logic go;
    logic proto_err;

    always_comb begin
        live      = e_req & ~e_kill;
        busy      = (cnt != '0);
        go        = live & ~busy;
        proto_err = live & busy;
        md_start  = go & ~e_kind[2];
        md_op     = '0;
        md_we     = '0;
        if (e_req && !e_kind[2])
            md_op = e_kind[1:0];
        if (go && e_kind == 3'd4)
            md_we = 2'd1;
        else if (go && e_kind == 3'd5)
            md_we = 2'd2;
        rd_hi   = e_req & (e_kind == 3'd6);
        stall_d = d_md & (busy | md_start);
    end

    // Odd kinds (DIVU/DIV) take the divide latency, even kinds the multiply latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            err          <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (md_start)
                cnt <= e_kind[0] ? DIV_LOAD : MUL_LOAD;
            else if (busy)
                cnt <= cnt - 5'd1;
            if (proto_err)
                err <= 1'b1;
            if (stall_d && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_md_sched_ctrl.sv
// Directed self-checking bench for md_sched_ctrl with hand-computed expectations.
module tb_md_sched_ctrl;

    logic        clk;
    logic        reset;
    logic        d_md;
    logic        e_req;
    logic        e_kill;
    logic [2:0]  e_kind;
    logic        md_start;
    logic [1:0]  md_op;
    logic [1:0]  md_we;
    logic        rd_hi;
    logic        busy;
    logic [4:0]  cnt;
    logic        stall_d;
    logic        err;
    logic [15:0] stall_cycles;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    md_sched_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .d_md(d_md), .e_req(e_req), .e_kill(e_kill),
        .e_kind(e_kind), .md_start(md_start), .md_op(md_op), .md_we(md_we),
        .rd_hi(rd_hi), .busy(busy), .cnt(cnt), .stall_d(stall_d), .err(err),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed at +1 and sampled at +2.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic d, input logic q, input logic k,
                         input logic [2:0] kind);
        reset = r; d_md = d; e_req = q; e_kill = k; e_kind = kind;
        #1;
    endtask

    initial begin
        reset = 1'b1; d_md = 1'b0; e_req = 1'b0; e_kill = 1'b0; e_kind = 3'd0;
        tick; tick;
        drive(0, 0, 0, 0, 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        chk("rst_md_start", 32'(md_start), 0);
        chk("rst_stall_d", 32'(stall_d), 0);

        // MULT with an MD op directly behind it
        drive(0, 1, 1, 0, 2);
        chk("mult_start", 32'(md_start), 1);
        chk("mult_op", 32'(md_op), 2);
        chk("mult_stall", 32'(stall_d), 1);
        chk("mult_we", 32'(md_we), 0);
        tick; drive(0, 1, 0, 0, 0);
        for (int i = 5; i >= 1; i--) begin
            chk("mult_cnt", 32'(cnt), 32'(i));
            chk("mult_busy", 32'(busy), 1);
            chk("mult_stall_hold", 32'(stall_d), 1);
            tick; drive(0, 1, 0, 0, 0);
        end
        chk("mult_done_cnt", 32'(cnt), 0);
        chk("mult_done_stall", 32'(stall_d), 0);
        chk("mult_stall_cycles", 32'(stall_cycles), 6);

        // DIVU, usable on cycle N+1 right after the MULT finished
        drive(0, 1, 1, 0, 1);
        chk("divu_start", 32'(md_start), 1);
        chk("divu_op", 32'(md_op), 1);
        tick; drive(0, 1, 0, 0, 0);
        for (int i = 10; i >= 1; i--) begin
            chk("divu_cnt", 32'(cnt), 32'(i));
            chk("divu_stall", 32'(stall_d), 1);
            tick; drive(0, 1, 0, 0, 0);
        end
        chk("divu_done_cnt", 32'(cnt), 0);
        chk("divu_done_stall", 32'(stall_d), 0);
        chk("divu_stall_cycles", 32'(stall_cycles), 17);

        // MTHI then MTLO while idle
        drive(0, 1, 1, 0, 4);
        chk("mthi_we", 32'(md_we), 1);
        chk("mthi_start", 32'(md_start), 0);
        chk("mthi_stall", 32'(stall_d), 0);
        tick; drive(0, 1, 1, 0, 5);
        chk("mtlo_we", 32'(md_we), 2);
        chk("mtlo_start", 32'(md_start), 0);
        chk("mtlo_busy", 32'(busy), 0);
        chk("mtlo_stall", 32'(stall_d), 0);
        tick; drive(0, 0, 0, 0, 0);
        chk("mt_cnt", 32'(cnt), 0);
        chk("mt_stall_cycles", 32'(stall_cycles), 17);

        // Killed MULT, then MFLO / MFHI
        drive(0, 0, 1, 1, 2);
        chk("kill_start", 32'(md_start), 0);
        chk("kill_we", 32'(md_we), 0);
        tick; drive(0, 0, 1, 0, 7);
        chk("kill_cnt", 32'(cnt), 0);
        chk("kill_err", 32'(err), 0);
        chk("mflo_rd_hi", 32'(rd_hi), 0);
        chk("mflo_we", 32'(md_we), 0);
        chk("mflo_start", 32'(md_start), 0);
        drive(0, 0, 1, 0, 6);
        chk("mfhi_rd_hi", 32'(rd_hi), 1);
        tick; drive(0, 0, 0, 0, 0);
        chk("mf_err", 32'(err), 0);

        // DIV, then a protocol-violating DIV at cnt=3
        drive(0, 0, 1, 0, 3);
        chk("div_start", 32'(md_start), 1);
        chk("div_op", 32'(md_op), 3);
        tick; drive(0, 0, 0, 0, 0);
        chk("div_cnt10", 32'(cnt), 10);
        for (int i = 0; i < 7; i++) begin
            tick; drive(0, 0, 0, 0, 0);
        end
        chk("div_cnt3", 32'(cnt), 3);
        drive(0, 0, 1, 0, 3);
        chk("viol_start", 32'(md_start), 0);
        chk("viol_we", 32'(md_we), 0);
        tick; drive(0, 0, 0, 0, 0);
        chk("viol_cnt2", 32'(cnt), 2);
        chk("viol_err", 32'(err), 1);
        tick; drive(0, 0, 0, 0, 0);
        chk("viol_cnt1", 32'(cnt), 1);
        tick; drive(0, 0, 0, 0, 0);
        chk("viol_cnt0", 32'(cnt), 0);
        chk("viol_err_sticky", 32'(err), 1);
        chk("viol_stall_cycles", 32'(stall_cycles), 17);

        // DIV aborted by reset at cnt=7, with a simultaneous request
        drive(0, 0, 1, 0, 3);
        tick; drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick; drive(0, 0, 0, 0, 0);
        end
        chk("abort_cnt7", 32'(cnt), 7);
        drive(1, 1, 1, 0, 2);
        tick; drive(0, 0, 0, 0, 0);
        chk("abort_cnt", 32'(cnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_stall_cycles", 32'(stall_cycles), 0);
        drive(0, 0, 1, 0, 0);
        chk("multu_start", 32'(md_start), 1);
        chk("multu_op", 32'(md_op), 0);
        tick; drive(0, 0, 0, 0, 0);
        chk("multu_cnt", 32'(cnt), 5);
        chk("multu_busy", 32'(busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched_ctrl.md
Name: md_sched_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide unit in the 5-stage MIPS pipeline.
- Decodes the E-stage MD-class instruction into the unit's start/op/write-enable controls and tracks unit occupancy with its own countdown.
- Stalls D-stage MD-class instructions (mult/div/mfhi/mflo/mthi/mtlo) while the unit is busy or being started.
- Provides a sticky protocol-error flag and a saturating stall-cycle counter.

Parameters:
MUL_CYCLES, 5, busy cycles after a MULT/MULTU start (1..31)
DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (1..31)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
d_md  input  1  D-stage instruction is MD-class (any of the 8 kinds)
e_req  input  1  E-stage instruction is MD-class and valid
e_kill  input  1  E-stage instruction annulled this cycle (exception/flush)
e_kind  input  3  0 MULTU, 1 DIVU, 2 MULT, 3 DIV, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
md_start  output  1  start pulse to unit
md_op  output  2  op to unit: 0 unsigned mul, 1 unsigned div, 2 signed mul, 3 signed div
md_we  output  2  1 = write HI, 2 = write LO, 0 = none
rd_hi  output  1  E-stage read select: 1 HI, 0 LO
busy  output  1  unit occupied (cnt != 0)
cnt  output  5  remaining busy cycles
stall_d  output  1  hold D stage (and freeze F/D), bubble into E
err  output  1  sticky protocol error
stall_cycles  output  CNT_W  count of cycles with stall_d=1, saturating

Behaviour:
- Reset: cnt=0, busy=0, err=0, stall_cycles=0. md_start, md_op, md_we, rd_hi and stall_d are combinational; they are 0 when there is no request. Reset mid-operation aborts tracking immediately: cnt=0 on the next cycle, no pending effects.
- go = e_req & ~e_kill & ~busy.
- md_start = go & (e_kind<=3). md_op = e_kind[1:0] whenever e_kind<=3, else 0.
- md_we = 1 if go & kind 4; 2 if go & kind 5; else 0.
- rd_hi = e_req & (e_kind==6). It is informational; mf reads are always permitted when not busy.
- Countdown on each edge:
  - md_start with kind 0 or 2: cnt <= MUL_CYCLES.
  - md_start with kind 1 or 3: cnt <= DIV_CYCLES.
  - Otherwise, if cnt != 0: cnt <= cnt-1.
  - Result: busy is high for exactly N cycles after the start edge; the unit is usable on cycle N+1.
- busy = (cnt != 0). There are two implicit states: IDLE (cnt=0) and BUSY (cnt>0). Transitions are IDLE->BUSY on md_start and BUSY->IDLE when cnt reaches 0.
- stall_d = d_md & (busy | md_start). An MD instruction directly behind a starting mult/div stalls.
- Stall does not depend on d_md kind; mthi/mtlo/mfhi/mflo are all held while busy.
- Error: if e_req & ~e_kill & busy, the request is ignored (no start, md_we=0, cnt unaffected) and err <= 1. err stays set until reset.
- Killed request (e_kill=1): no start, no write, no error, cnt unaffected.
- Division by zero is not special-cased here; DIV_CYCLES still applies.
- stall_cycles increments on each edge where stall_d=1 and saturates at all-ones.
- Simultaneous reset and request: reset wins, and no state is updated from the request.

Test Plan:
- Reset, then e_req, kind=2 (MULT), d_md=1 same cycle -> md_start=1, md_op=2, stall_d=1; busy for 5 cycles (cnt 5,4,3,2,1); stall_d drops on cycle 6; stall_cycles=6.
- Kind=1 (DIVU), then d_md=1 held -> busy 10 cycles, cnt decrements 10..1, stall_d=1 for 10 cycles after start, then 0.
- IDLE, kind=4 then kind=5 on consecutive cycles -> md_we=1 then 2, md_start=0, busy stays 0, no stall.
- MULT with e_kill=1 -> md_start=0, cnt stays 0, err stays 0; kind=7 without kill -> rd_hi=0, md_we=0.
- Force e_req kind=3 while cnt=3 -> md_start=0, cnt continues 2,1,0, err=1 and stays 1.
- DIV start, reset asserted at cnt=7 -> next cycle cnt=0, busy=0, err=0, stall_cycles=0; new MULTU is then accepted and cnt=5.
